wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage for the MIPS32 pipeline. It sits between the MEM stage and the register file, and it owns the register file's single write port (`we`, `waddr`, `wdata`). It retires ALU results one cycle after acceptance. For loads it waits a variable number of cycles for the data-memory response, then aligns and extends the returned word before writing it. It also reports a pending load to the hazard unit so that dependent reads are stalled.

## Interface
Parameters:
- `DATA_W`, 32: register and data width.
- `REG_ADDR_W`, 5: register address width (32 registers).

Ports:
- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted at 0).
- `in_valid` in 1: MEM stage presents an instruction.
- `in_ready` out 1: stage can accept; transfer occurs when `in_valid && in_ready` at a rising edge.
- `in_wreg` in 1: instruction writes a destination register.
- `in_waddr` in `REG_ADDR_W`: destination register.
- `in_wdata` in `DATA_W`: ALU/move result for non-loads.
- `in_is_load` in 1: instruction is a load.
- `in_load_op` in 3: load type; encodings come from the package.
- `in_addr_lo` in 2: effective address bits [1:0].
- `dmem_rvalid` in 1: data-memory read data valid, one-cycle pulse.
- `dmem_rdata` in `DATA_W`: data-memory read word, little-endian (byte k = bits [8k+7:8k]).
- `we` out 1: register file write enable; registered; pulses exactly one cycle per write.
- `waddr` out `REG_ADDR_W`: register file write address; registered.
- `wdata` out `DATA_W`: register file write data; registered.
- `load_busy` out 1: a load is waiting for its memory response.
- `busy_waddr` out `REG_ADDR_W`: destination of the pending load; 0 when `load_busy` = 0.
- `proto_err` out 1: sticky flag; `dmem_rvalid` arrived while no load was pending.

## Operation
- FSM has two states, IDLE and WAIT_LOAD. `in_ready` = (state == IDLE); it is combinational from state only.
- IDLE, accept with `in_is_load` = 0:
  - if `in_wreg` = 1 and `in_waddr` != 0: register `we` = 1, `waddr` = `in_waddr`, `wdata` = `in_wdata`;
  - otherwise `we` = 0.
  - State stays IDLE.
- IDLE, accept with `in_is_load` = 1:
  - capture `in_waddr`, `in_wreg`, `in_load_op`, `in_addr_lo`; go to WAIT_LOAD;
  - `we` = 0 the next cycle.
- WAIT_LOAD without `dmem_rvalid`: hold; `we` = 0.
- WAIT_LOAD with `dmem_rvalid`:
  - `wdata` = aligned result; `we` = captured wreg AND (captured waddr != 0); go to IDLE.
- Alignment:
  - LB/LBU: select byte `addr_lo`; sign-extend (LB) or zero-extend (LBU).
  - LH/LHU: select halfword `addr_lo[1]`, ignoring `addr_lo[0]`; sign/zero-extend.
  - LW: full word, `addr_lo` ignored.
  - Undefined `load_op` values are treated as LW.
- `we` is 0 on every cycle not listed above; `waddr` and `wdata` hold their last value when `we` = 0.
- `load_busy` = (state == WAIT_LOAD); `busy_waddr` = captured waddr when busy, else 0.
- `dmem_rvalid` in IDLE is ignored for writing and sets `proto_err`. Only reset clears `proto_err`.
- Reset, including mid-load, forces: state IDLE, `we` = 0, `waddr` = 0, `wdata` = 0, `proto_err` = 0, captured fields = 0. A pending load is dropped. A late `dmem_rvalid` after reset sets `proto_err`.

## Timing
- Non-load: accepted at edge n gives `we` high during cycle n+1. Sustained throughput is 1 per cycle.
- Load: accepted at edge n; `dmem_rvalid` is sampled from edge n+1 onward. An rvalid at edge m gives `we` high during cycle m+1.
- `in_ready` is low from the cycle after load acceptance through the cycle in which rvalid is sampled. The next accept is at edge m+1, so a load costs at least one bubble.
- `dmem_rvalid` asserted in the same cycle as load acceptance is seen in IDLE and therefore sets `proto_err`.
- No combinational path exists from any input to `we`/`waddr`/`wdata`.

## Structure
- Shared package / defines file holds:
  - `LOAD_LB`=3'd0, `LOAD_LBU`=3'd1, `LOAD_LH`=3'd2, `LOAD_LHU`=3'd3, `LOAD_LW`=3'd4;
  - state encodings;
  - `ZeroWord`, `RegBus`, `RegAddrBus` widths, reused from the existing defines.
- One combinational sub-module, `load_align` (inputs rdata, load_op, addr_lo; output aligned word). The FSM and output registers live in `wb_stage`.

## Test plan
- ALU stream: accept `in_waddr`=3 `in_wdata`=0x11 and then `in_waddr`=4 `in_wdata`=0x22 on consecutive edges -> `we` pulses two cycles, (3,0x11) then (4,0x22).
- Zero/no-write: `in_waddr`=0 with `in_wreg`=1, and `in_waddr`=5 with `in_wreg`=0 -> `we` stays 0.
- Loads with rdata=0x8899AABB:
  - LB `addr_lo`=2 -> `wdata`=0xFFFFFF99;
  - LBU `addr_lo`=0 -> 0x000000BB;
  - LH `addr_lo`=2 -> 0xFFFF8899;
  - LHU `addr_lo`=0 -> 0x0000AABB;
  - LW -> 0x8899AABB.
- Variable latency: load to r7, rvalid 4 cycles later -> `load_busy`=1 and `busy_waddr`=7 throughout; `in_ready`=0 throughout; `we` pulses one cycle after rvalid; `in_valid` held high is accepted at the following edge.
- Reset mid-load: assert `rst`=0 while in WAIT_LOAD -> all outputs 0 immediately (asynchronous); rvalid after release -> no write, `proto_err`=1.
- Spurious rvalid while IDLE -> no write, `proto_err`=1 and sticky until reset.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the MIPS32 write-back stage.
// Load-type encodings, FSM states and the datapath widths reused across the pipeline.
package wb_stage_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam logic [RegBus-1:0] ZeroWord = '0;

    localparam logic [2:0] LOAD_LB  = 3'd0;
    localparam logic [2:0] LOAD_LBU = 3'd1;
    localparam logic [2:0] LOAD_LH  = 3'd2;
    localparam logic [2:0] LOAD_LHU = 3'd3;
    localparam logic [2:0] LOAD_LW  = 3'd4;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: picks the addressed byte/halfword of a
// little-endian memory word and sign- or zero-extends it.
module load_align
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = RegBus
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [2:0]        load_op,
    input  logic [1:0]        addr_lo,
    output logic [DATA_W-1:0] aligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfword selection ignores addr_lo[0]; unknown load types fall back to a full word.
    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
        case (load_op)
            LOAD_LB:  aligned = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LOAD_LBU: aligned = {{(DATA_W-8){1'b0}}, byte_sel};
            LOAD_LH:  aligned = {{(DATA_W-16){half_sel[15]}}, half_sel};
            LOAD_LHU: aligned = {{(DATA_W-16){1'b0}}, half_sel};
            default:  aligned = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: owns the register-file write port, retires ALU results
// directly and parks in WAIT_LOAD until the data-memory response arrives.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W     = RegBus,
    parameter int REG_ADDR_W = RegAddrBus
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_wreg,
    input  logic [REG_ADDR_W-1:0] in_waddr,
    input  logic [DATA_W-1:0]     in_wdata,
    input  logic                  in_is_load,
    input  logic [2:0]            in_load_op,
    input  logic [1:0]            in_addr_lo,
    input  logic                  dmem_rvalid,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0]     wdata,
    output logic                  load_busy,
    output logic [REG_ADDR_W-1:0] busy_waddr,
    output logic                  proto_err
);

    wb_state_e             state_q, state_d;
    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  proto_err_q, proto_err_d;
    logic [REG_ADDR_W-1:0] cap_waddr_q, cap_waddr_d;
    logic                  cap_wreg_q, cap_wreg_d;
    logic [2:0]            cap_op_q, cap_op_d;
    logic [1:0]            cap_lo_q, cap_lo_d;
    logic [DATA_W-1:0]     aligned;

    load_align #(.DATA_W(DATA_W)) u_align (
        .rdata   (dmem_rdata),
        .load_op (cap_op_q),
        .addr_lo (cap_lo_q),
        .aligned (aligned)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        proto_err_d = proto_err_q;
        cap_waddr_d = cap_waddr_q;
        cap_wreg_d  = cap_wreg_q;
        cap_op_d    = cap_op_q;
        cap_lo_d    = cap_lo_q;
        case (state_q)
            ST_IDLE: begin
                // A response with nothing outstanding is a protocol violation, never a write.
                if (dmem_rvalid) begin
                    proto_err_d = 1'b1;
                end
                if (in_valid) begin
                    if (in_is_load) begin
                        cap_waddr_d = in_waddr;
                        cap_wreg_d  = in_wreg;
                        cap_op_d    = in_load_op;
                        cap_lo_d    = in_addr_lo;
                        state_d     = ST_WAIT_LOAD;
                    end else if (in_wreg && (in_waddr != '0)) begin
                        we_d    = 1'b1;
                        waddr_d = in_waddr;
                        wdata_d = in_wdata;
                    end
                end
            end
            ST_WAIT_LOAD: begin
                if (dmem_rvalid) begin
                    state_d = ST_IDLE;
                    if (cap_wreg_q && (cap_waddr_q != '0)) begin
                        we_d    = 1'b1;
                        waddr_d = cap_waddr_q;
                        wdata_d = aligned;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= ZeroWord[DATA_W-1:0];
            proto_err_q <= 1'b0;
            cap_waddr_q <= '0;
            cap_wreg_q  <= 1'b0;
            cap_op_q    <= '0;
            cap_lo_q    <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            proto_err_q <= proto_err_d;
            cap_waddr_q <= cap_waddr_d;
            cap_wreg_q  <= cap_wreg_d;
            cap_op_q    <= cap_op_d;
            cap_lo_q    <= cap_lo_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign load_busy  = (state_q == ST_WAIT_LOAD);
    assign busy_waddr = load_busy ? cap_waddr_q : '0;
    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected register writes,
// a forked monitor pops and compares them whenever we is high.
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_wreg = 1'b0;
    logic [4:0]  in_waddr = '0;
    logic [31:0] in_wdata = '0;
    logic        in_is_load = 1'b0;
    logic [2:0]  in_load_op = '0;
    logic [1:0]  in_addr_lo = '0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        load_busy;
    logic [4:0]  busy_waddr;
    logic        proto_err;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    wb_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_wreg     (in_wreg),
        .in_waddr    (in_waddr),
        .in_wdata    (in_wdata),
        .in_is_load  (in_is_load),
        .in_load_op  (in_load_op),
        .in_addr_lo  (in_addr_lo),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .load_busy   (load_busy),
        .busy_waddr  (busy_waddr),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {27'd0, waddr}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", {27'd0, waddr}, {27'd0, e.a});
                    check("write_data", wdata, e.d);
                end
            end
        end
    endtask

    task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Present one non-load for a single edge; caller is at posedge+1.
    task automatic send_alu(input logic wreg, input logic [4:0] a, input logic [31:0] d);
        in_valid   = 1'b1;
        in_is_load = 1'b0;
        in_wreg    = wreg;
        in_waddr   = a;
        in_wdata   = d;
        if (wreg && a != 5'd0) push_exp(a, d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Issue a load, return rvalid after lat cycles; hold_next keeps an ALU op waiting.
    task automatic send_load(input logic [2:0] op, input logic [1:0] lo, input logic [4:0] a,
                             input int lat, input logic [31:0] rd, input logic [31:0] exp_d,
                             input logic hold_next);
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_wreg    = 1'b1;
        in_waddr   = a;
        in_load_op = op;
        in_addr_lo = lo;
        @(posedge clk);
        #1;
        in_valid   = hold_next;
        in_is_load = 1'b0;
        in_waddr   = 5'd9;
        in_wdata   = 32'h0000_ABCD;
        for (int i = 1; i <= lat; i++) begin
            if (i == lat) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = rd;
                if (a != 5'd0) push_exp(a, exp_d);
                if (hold_next) push_exp(5'd9, 32'h0000_ABCD);
            end
            @(negedge clk);
            check("busy_flag", {31'd0, load_busy}, 32'd1);
            check("busy_waddr", {27'd0, busy_waddr}, {27'd0, a});
            check("ready_low", {31'd0, in_ready}, 32'd0);
            check("no_we_wait", {31'd0, we}, 32'd0);
            @(posedge clk);
            #1;
        end
        dmem_rvalid = 1'b0;
        @(negedge clk);
        check("ready_back", {31'd0, in_ready}, 32'd1);
        check("busy_clear", {27'd0, busy_waddr}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        fork
            monitor();
            begin
                #200000;
                $display("[TB] FAIL watchdog: got timeout expected finish");
                $fatal(1, "[TB] watchdog expired");
            end
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_waddr", {27'd0, waddr}, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_proto", {31'd0, proto_err}, 32'd0);
        check("rst_busy", {31'd0, load_busy}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);

        send_alu(1'b1, 5'd3, 32'h11);
        send_alu(1'b1, 5'd4, 32'h22);
        idle(2);

        send_alu(1'b1, 5'd0, 32'h33);
        send_alu(1'b0, 5'd5, 32'h44);
        @(negedge clk);
        check("nowrite_we", {31'd0, we}, 32'd0);
        idle(1);

        send_load(LOAD_LB,  2'd2, 5'd10, 1, 32'h8899AABB, 32'hFFFFFF99, 1'b0);
        send_load(LOAD_LBU, 2'd0, 5'd11, 1, 32'h8899AABB, 32'h000000BB, 1'b0);
        send_load(LOAD_LH,  2'd2, 5'd12, 2, 32'h8899AABB, 32'hFFFF8899, 1'b0);
        send_load(LOAD_LHU, 2'd0, 5'd13, 1, 32'h8899AABB, 32'h0000AABB, 1'b0);
        send_load(LOAD_LW,  2'd3, 5'd14, 1, 32'h8899AABB, 32'h8899AABB, 1'b0);
        send_load(LOAD_LB,  2'd1, 5'd15, 1, 32'h8899AABB, 32'hFFFFFFAA, 1'b0);
        send_load(LOAD_LBU, 2'd3, 5'd16, 1, 32'h8899AABB, 32'h00000088, 1'b0);
        send_load(LOAD_LH,  2'd3, 5'd17, 1, 32'h8899AABB, 32'hFFFF8899, 1'b0);
        send_load(3'd7,     2'd1, 5'd18, 1, 32'h8899AABB, 32'h8899AABB, 1'b0);
        send_load(LOAD_LW,  2'd0, 5'd0,  1, 32'h8899AABB, 32'h8899AABB, 1'b0);

        send_load(LOAD_LW, 2'd0, 5'd7, 4, 32'h12345678, 32'h12345678, 1'b1);
        idle(2);

        @(negedge clk);
        check("proto_before", {31'd0, proto_err}, 32'd0);
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        check("spurious_we", {31'd0, we}, 32'd0);
        check("proto_set", {31'd0, proto_err}, 32'd1);
        idle(3);
        send_alu(1'b1, 5'd20, 32'h55);
        idle(1);
        @(negedge clk);
        check("proto_sticky", {31'd0, proto_err}, 32'd1);

        @(posedge clk);
        #1;
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_wreg    = 1'b1;
        in_waddr   = 5'd6;
        in_load_op = LOAD_LW;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, load_busy}, 32'd0);
        check("mid_rst_bwaddr", {27'd0, busy_waddr}, 32'd0);
        check("mid_rst_waddr", {27'd0, waddr}, 32'd0);
        check("mid_rst_wdata", wdata, 32'd0);
        check("mid_rst_proto", {31'd0, proto_err}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        check("late_rvalid_we", {31'd0, we}, 32'd0);
        check("late_rvalid_proto", {31'd0, proto_err}, 32'd1);
        idle(3);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
